watch_disp_scan: RTL and testbench

//  Six-digit multiplexed 7-segment scanner directly downstream of the stopwatch counter chain.

---
 rtl/watch_disp_scan.sv | 143 ++++++++++++++
 tb/tb_watch_disp_scan.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/watch_disp_scan.sv
// Six-digit multiplexed 7-segment scanner for the stopwatch display.
// Each frame is taken from one snapshot of the packed BCD display buffer.
// On top of plain decoding it adds leading-zero blanking, a blink mode
// and a dash for non-decimal nibbles.
// All outputs are registered. They are computed from the next-state values,
// so the digit on the pins always matches the idx register in the same cycle.
module watch_disp_scan #(
  parameter int DWELL       = 2,
  parameter int BLINK_HALF  = 250,
  parameter int LZ_LOW      = 4,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1
) (
  input  logic        clk_1Khz,
  input  logic        rst,
  input  logic [23:0] dispbuf,
  input  logic        blank_lz,
  input  logic        blink,
  input  logic [5:0]  dp_mask,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [5:0]  an
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  // Inactive output levels in the configured polarity.
  localparam logic [6:0] SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = (SEG_ACT_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [5:0] AN_OFF  = (AN_ACT_LOW != 0) ? 6'h3F : 6'h00;

  // Scan, snapshot and blink state.
  logic [2:0]    idx, nxt_idx;
  logic [DW-1:0] dwell, nxt_dwell;
  logic [23:0]   snap, nxt_snap;
  logic [BW-1:0] blink_cnt, nxt_blink_cnt;
  logic          blink_ph, nxt_blink_ph;

  // Active-high intermediate values for the next cycle's display.
  logic [3:0] cur_nib;
  logic [5:0] zero_run;
  logic       run;
  logic       blank_hit;
  logic       blink_off;
  logic [6:0] seg_lit;
  logic       dp_lit;
  logic [5:0] an_sel;

  // Segment pattern (bit0=a .. bit6=g, 1 = lit). Nibbles A-F show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_decode = 7'b0111111;
      4'd1:    seg_decode = 7'b0000110;
      4'd2:    seg_decode = 7'b1011011;
      4'd3:    seg_decode = 7'b1001111;
      4'd4:    seg_decode = 7'b1100110;
      4'd5:    seg_decode = 7'b1101101;
      4'd6:    seg_decode = 7'b1111101;
      4'd7:    seg_decode = 7'b0000111;
      4'd8:    seg_decode = 7'b1111111;
      4'd9:    seg_decode = 7'b1101111;
      default: seg_decode = 7'b1000000;
    endcase
  endfunction

  // Next-state logic. Scan position and blink timer advance every cycle;
  // the buffer is captured only when the scan wraps to digit 0.
  always_comb begin
    nxt_dwell     = dwell + 1'b1;
    nxt_idx       = idx;
    nxt_snap      = snap;
    nxt_blink_cnt = blink_cnt + 1'b1;
    nxt_blink_ph  = blink_ph;
    if (dwell == DWELL_LAST) begin
      nxt_dwell = '0;
      if (idx == 3'd5) begin
        nxt_idx  = 3'd0;
        nxt_snap = dispbuf;
      end else begin
        nxt_idx = idx + 3'd1;
      end
    end
    if (blink_cnt == BLINK_LAST) begin
      nxt_blink_cnt = '0;
      nxt_blink_ph  = ~blink_ph;
    end
  end

  // Display decode for the digit that will be selected next cycle.
  // Priority for seg: blink-off, then leading-zero blank, then decode.
  always_comb begin
    cur_nib = 4'h0;
    case (nxt_idx)
      3'd0:    cur_nib = nxt_snap[3:0];
      3'd1:    cur_nib = nxt_snap[7:4];
      3'd2:    cur_nib = nxt_snap[11:8];
      3'd3:    cur_nib = nxt_snap[15:12];
      3'd4:    cur_nib = nxt_snap[19:16];
      3'd5:    cur_nib = nxt_snap[23:20];
      default: cur_nib = 4'h0;
    endcase
    // zero_run[k]: nibble k and every nibble above it are zero.
    zero_run = '0;
    run      = 1'b1;
    for (int k = 5; k >= 0; k--) begin
      run         = run & (nxt_snap[4*k +: 4] == 4'h0);
      zero_run[k] = run;
    end
    blank_hit = blank_lz && (nxt_idx >= 3'(LZ_LOW)) && (nxt_idx <= 3'd5) && zero_run[nxt_idx];
    blink_off = blink && !nxt_blink_ph;
    if (blink_off || blank_hit) seg_lit = 7'b0000000;
    else                        seg_lit = seg_decode(cur_nib);
    dp_lit = !blink_off && (nxt_idx <= 3'd5) && dp_mask[nxt_idx];
    an_sel = 6'b000001 << nxt_idx;
  end

  // State and output registers; reset forces every output inactive.
  always_ff @(posedge clk_1Khz) begin
    if (rst) begin
      idx       <= 3'd0;
      dwell     <= '0;
      snap      <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b1;
      seg       <= SEG_OFF;
      dp        <= DP_OFF;
      an        <= AN_OFF;
    end else begin
      idx       <= nxt_idx;
      dwell     <= nxt_dwell;
      snap      <= nxt_snap;
      blink_cnt <= nxt_blink_cnt;
      blink_ph  <= nxt_blink_ph;
      seg       <= (SEG_ACT_LOW != 0) ? ~seg_lit : seg_lit;
      dp        <= (SEG_ACT_LOW != 0) ? ~dp_lit : dp_lit;
      an        <= (AN_ACT_LOW != 0) ? ~an_sel : an_sel;
    end
  end

endmodule

// File: tb/tb_watch_disp_scan.sv
// Self-checking bench for watch_disp_scan (DWELL=2, BLINK_HALF=4, active-low).
// The bench keeps its own count of edges since reset release. From that count
// it knows the frame position and blink phase without reading the DUT.
module tb_watch_disp_scan;

  localparam int DWELL = 2;
  localparam int FRAME = 6 * DWELL;

  // Active-low segment patterns (bit0=a .. bit6=g).
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SB = 7'b1111111;

  logic        clk_1Khz;
  logic        rst;
  logic [23:0] dispbuf;
  logic        blank_lz;
  logic        blink;
  logic [5:0]  dp_mask;
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  an;

  watch_disp_scan #(
    .DWELL(DWELL), .BLINK_HALF(4), .LZ_LOW(4), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)
  ) dut (
    .clk_1Khz(clk_1Khz), .rst(rst), .dispbuf(dispbuf), .blank_lz(blank_lz),
    .blink(blink), .dp_mask(dp_mask), .seg(seg), .dp(dp), .an(an)
  );

  // Clock and reset-state defaults.
  initial clk_1Khz = 1'b0;
  always #5 clk_1Khz = ~clk_1Khz;

  // Vector record: inputs plus expected seg per digit (digit 5 first) and dp per digit.
  typedef struct packed {
    logic [23:0]      buf_v;
    logic             lz;
    logic [5:0]       dpm;
    logic [5:0][6:0]  eseg;
    logic [5:0]       edp;
  } vec_t;

  vec_t vecs[8];

  // Scoreboard: {an, seg, dp} expected per cycle.
  logic [13:0] exp_q[$];
  int checks;
  int errors;
  int n;   // edges since reset release

  // Advance one clock edge and settle; inputs change only here.
  task automatic step();
    @(posedge clk_1Khz);
    #1;
    if (rst) n = 0;
    else     n = n + 1;
  endtask

  function automatic logic [5:0] an_exp(input int pos);
    logic [5:0] one;
    one = 6'b000001;
    return ~(one << (pos / DWELL));
  endfunction

  // Pop the oldest expectation and compare against the DUT pins.
  task automatic check_out(input string name);
    logic [13:0] e;
    logic [13:0] got;
    got = {an, seg, dp};
    checks = checks + 1;
    if (exp_q.size() == 0) begin
      errors = errors + 1;
      $display("FAIL %s: scoreboard empty, got an=%b seg=%b dp=%b", name, an, seg, dp);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        errors = errors + 1;
        $display("FAIL %s n=%0d: got an=%b seg=%b dp=%b, need an=%b seg=%b dp=%b",
                 name, n, an, seg, dp, e[13:8], e[7:1], e[0]);
      end
    end
  endtask

  task automatic run_cycle(input logic [13:0] e, input string name);
    exp_q.push_back(e);
    step();
    check_out(name);
  endtask

  // Step without checking until the last shown position equals p.
  task automatic goto_pos(input int p);
    for (int i = 0; i < FRAME && (n % FRAME) != p; i++) step();
  endtask

  initial begin
    int pos;
    int nn;
    bit on;
    checks = 0;
    errors = 0;
    n = 0;

    vecs[0] = '{24'h123456, 1'b0, 6'h00, {S1, S2, S3, S4, S5, S6}, 6'h3F};
    vecs[1] = '{24'h005912, 1'b1, 6'h21, {SB, SB, S5, S9, S1, S2}, 6'h1E};
    vecs[2] = '{24'h050000, 1'b1, 6'h00, {SB, S5, S0, S0, S0, S0}, 6'h3F};
    vecs[3] = '{24'h00000A, 1'b0, 6'h3F, {S0, S0, S0, S0, S0, SD}, 6'h00};
    vecs[4] = '{24'h000000, 1'b1, 6'h00, {SB, SB, S0, S0, S0, S0}, 6'h3F};
    vecs[5] = '{24'h0B0870, 1'b0, 6'h10, {S0, SD, S0, S8, S7, S0}, 6'h2F};
    vecs[6] = '{24'h100000, 1'b1, 6'h00, {S1, S0, S0, S0, S0, S0}, 6'h3F};
    vecs[7] = '{24'h009000, 1'b1, 6'h00, {SB, SB, S9, S0, S0, S0}, 6'h3F};

    // Reset: outputs inactive; first frame after release shows snap=0.
    rst = 1'b1; dispbuf = 24'h123456; blank_lz = 1'b0; blink = 1'b0; dp_mask = 6'h00;
    for (int i = 0; i < 3; i++) run_cycle({6'h3F, 7'h7F, 1'b1}, "reset");
    rst = 1'b0;
    for (int p = 1; p < FRAME; p++) run_cycle({an_exp(p), S0, 1'b1}, "first_frame");

    // Table-driven frames: each vector is snapshotted at a frame boundary.
    for (int v = 0; v < 8; v++) begin
      dispbuf = vecs[v].buf_v; blank_lz = vecs[v].lz; dp_mask = vecs[v].dpm;
      goto_pos(FRAME - 1);
      for (int p = 0; p < FRAME; p++)
        run_cycle({an_exp(p), vecs[v].eseg[p / DWELL], vecs[v].edp[p / DWELL]}, "vector");
    end

    // Mid-frame buffer change stays invisible until the next frame.
    dispbuf = 24'h123456; blank_lz = 1'b0; dp_mask = 6'h00;
    goto_pos(FRAME - 1);
    for (int p = 0; p < FRAME; p++) begin
      run_cycle({an_exp(p), vecs[0].eseg[p / DWELL], 1'b1}, "no_tear");
      if (p == 2 * DWELL) dispbuf = 24'h999999;
    end
    for (int p = 0; p < FRAME; p++) run_cycle({an_exp(p), S9, 1'b1}, "next_frame");

    // Blink: 4 cycles on, 4 off, phase counted from reset release.
    dispbuf = 24'h123456; dp_mask = 6'h04;
    goto_pos(FRAME - 1);
    blink = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      nn  = n + 1;
      pos = nn % FRAME;
      on  = ((nn / 4) % 2) == 0;
      run_cycle({an_exp(pos), on ? vecs[0].eseg[pos / DWELL] : SB,
                 (on && (pos / DWELL) == 2) ? 1'b0 : 1'b1}, "blink");
    end
    blink = 1'b0; dp_mask = 6'h00;

    // Reset mid-frame at idx 3, then restart at idx 0 showing 0.
    goto_pos(3 * DWELL);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) run_cycle({6'h3F, 7'h7F, 1'b1}, "mid_reset");
    rst = 1'b0;
    for (int p = 1; p < FRAME; p++) run_cycle({an_exp(p), S0, 1'b1}, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
